// File: rtl/mr_prime_tester.sv
// Miller-Rabin primality tester: valid/ready candidate in, valid/ready verdict out.
// Define MR_TRIAL_DIV_EN to add a trial-division pass (3,5,7,11,13) ahead of the MR rounds.
module mr_prime_tester #(
  parameter int          WORD_WIDTH = 32,
  parameter int          MAX_ROUNDS = 12,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] n,
  input  logic [5:0]            security_parameter,
  input  logic                  witness_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  is_prime,
  output logic [5:0]            rounds_run,
  output logic                  busy
);

  localparam int W  = WORD_WIDTH;
  localparam int EW = $clog2(W + 1);
  localparam int SW = $clog2(W);
  localparam logic [31:0]  SEED  = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
  localparam logic [W-1:0] ONE   = W'(1);
  localparam logic [W-1:0] TWO   = W'(2);
  localparam logic [W-1:0] THREE = W'(3);

  typedef enum logic [2:0] {
    IDLE, PRECHK,
`ifdef MR_TRIAL_DIV_EN
    TDIV,
`endif
    DECOMP, PICK, EXP, SQR, DONE
  } state_t;
  typedef enum logic [1:0] {E_SCAN, E_SQ, E_MUL} eph_t;

  function automatic logic [5:0] base_of(input logic [3:0] i);
    case (i)
      4'd0: base_of = 6'd2;    4'd1: base_of = 6'd3;    4'd2: base_of = 6'd5;
      4'd3: base_of = 6'd7;    4'd4: base_of = 6'd11;   4'd5: base_of = 6'd13;
      4'd6: base_of = 6'd17;   4'd7: base_of = 6'd19;   4'd8: base_of = 6'd23;
      4'd9: base_of = 6'd29;   4'd10: base_of = 6'd31;  default: base_of = 6'd37;
    endcase
  endfunction

  state_t state, state_nxt;
  eph_t eph, eph_nxt;
  logic [W-1:0] n_r, n_nxt, d_r, d_nxt, a_r, a_nxt, x_r, x_nxt, e_d, ed_nxt;
  logic [SW-1:0] s_r, s_nxt, sq_left, sq_nxt;
  logic [EW-1:0] e_cnt, ecnt_nxt;
  logic [3:0] r_tgt, r_nxt, idx, idx_nxt, r_in;
  logic [5:0] rr_r, rr_nxt;
  logic prime_r, prime_nxt, mode_r, mode_nxt, started, started_nxt, sq_first, first_nxt;
  logic [31:0] lfsr, lfsr_nxt, lfsr_step;
  logic [W-1:0] lfsr_tiled, n_mask, lfsr_cand, base_w, n_m1, n_m2;
  logic round_pass, round_fail;

  logic mul_start, mul_busy, mul_done;
  logic [W-1:0] mul_in_a, mul_in_b, mul_ma, mul_mb;
  logic [W+1:0] mul_acc, mul_dbl, mul_add, n_ext;
  logic [EW-1:0] mul_cnt;

`ifdef MR_TRIAL_DIV_EN
  logic [2:0] p_idx, p_idx_nxt;
  logic [4:0] rem, rem_nxt, prime_p, rem_new;
  logic [5:0] rem_x;
  logic [W-1:0] t_sh, t_sh_nxt;
  logic [EW-1:0] t_cnt, t_cnt_nxt;

  always_comb begin
    case (p_idx)
      3'd0: prime_p = 5'd3;   3'd1: prime_p = 5'd5;   3'd2: prime_p = 5'd7;
      3'd3: prime_p = 5'd11;  default: prime_p = 5'd13;
    endcase
    rem_x   = {rem, t_sh[W-1]};
    rem_new = (rem_x >= {1'b0, prime_p}) ? 5'(rem_x - {1'b0, prime_p}) : rem_x[4:0];
  end
`endif

  // Witness LFSR is tiled across the word, then masked to the bit length of n.
  for (genvar k = 0; k < W; k++) begin : g_bits
    assign lfsr_tiled[k] = lfsr[k % 32];
    assign n_mask[k]     = |n_r[W-1:k];
  end

  assign lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ 32'h8020_0003) : (lfsr >> 1);
  assign lfsr_cand = lfsr_tiled & n_mask;
  assign base_w    = {{(W-6){1'b0}}, base_of(idx)};
  assign n_m1      = n_r - ONE;
  assign n_m2      = n_r - TWO;
  assign n_ext     = {2'b00, n_r};
  assign r_in      = (security_parameter == 6'd0) ? 4'd1 :
                     (security_parameter > 6'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : security_parameter[3:0];

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE) && (state != DONE);
  assign is_prime   = prime_r;
  assign rounds_run = rr_r;

  // Shared interleaved modular multiplier: r <- 2r (+a) mod n, one B bit per cycle.
  assign mul_done = mul_busy && (mul_cnt == '0);
  always_comb begin
    mul_dbl = mul_acc << 1;
    if (mul_dbl >= n_ext) mul_dbl = mul_dbl - n_ext;
    mul_add = mul_dbl + {2'b00, mul_ma};
    if (mul_add >= n_ext) mul_add = mul_add - n_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_busy <= 1'b0; mul_cnt <= '0; mul_acc <= '0; mul_ma <= '0; mul_mb <= '0;
    end else if (mul_start) begin
      mul_busy <= 1'b1; mul_cnt <= EW'(W); mul_acc <= '0; mul_ma <= mul_in_a; mul_mb <= mul_in_b;
    end else if (mul_done) begin
      mul_busy <= 1'b0;
    end else if (mul_busy) begin
      mul_acc <= mul_mb[W-1] ? mul_add : mul_dbl;
      mul_mb  <= mul_mb << 1;
      mul_cnt <= mul_cnt - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state; n_nxt = n_r; d_nxt = d_r; s_nxt = s_r; r_nxt = r_tgt; idx_nxt = idx;
    rr_nxt = rr_r; prime_nxt = prime_r; mode_nxt = mode_r; a_nxt = a_r; x_nxt = x_r;
    ed_nxt = e_d; ecnt_nxt = e_cnt; eph_nxt = eph; started_nxt = started; first_nxt = sq_first;
    sq_nxt = sq_left; lfsr_nxt = lfsr;
    mul_start = 1'b0; mul_in_a = x_r; mul_in_b = x_r;
    round_pass = 1'b0; round_fail = 1'b0;
`ifdef MR_TRIAL_DIV_EN
    p_idx_nxt = p_idx; rem_nxt = rem; t_sh_nxt = t_sh; t_cnt_nxt = t_cnt;
`endif
    case (state)
      IDLE: if (in_valid) begin
        n_nxt = n; r_nxt = r_in; mode_nxt = witness_mode;
        idx_nxt = '0; rr_nxt = '0; prime_nxt = 1'b0; state_nxt = PRECHK;
      end
      PRECHK: begin
        d_nxt = n_m1; s_nxt = '0;
        if (n_r < TWO) state_nxt = DONE;
        else if (n_r == TWO || n_r == THREE) begin prime_nxt = 1'b1; state_nxt = DONE; end
        else if (!n_r[0]) state_nxt = DONE;
        else begin
`ifdef MR_TRIAL_DIV_EN
          p_idx_nxt = '0; rem_nxt = '0; t_sh_nxt = n_r; t_cnt_nxt = EW'(W); state_nxt = TDIV;
`else
          state_nxt = DECOMP;
`endif
        end
      end
`ifdef MR_TRIAL_DIV_EN
      TDIV: begin
        rem_nxt = rem_new; t_sh_nxt = t_sh << 1; t_cnt_nxt = t_cnt - 1'b1;
        if (t_cnt == EW'(1)) begin
          if (n_r == W'(prime_p)) state_nxt = DECOMP;
          else if (rem_new == 5'd0) state_nxt = DONE;
          else if (p_idx == 3'd4) state_nxt = DECOMP;
          else begin p_idx_nxt = p_idx + 3'd1; rem_nxt = '0; t_sh_nxt = n_r; t_cnt_nxt = EW'(W); end
        end
      end
`endif
      DECOMP: if (!d_r[0]) begin d_nxt = d_r >> 1; s_nxt = s_r + 1'b1; end
              else state_nxt = PICK;
      PICK: begin
        ed_nxt = d_r; ecnt_nxt = EW'(W); eph_nxt = E_SCAN; started_nxt = 1'b0;
        if (!mode_r) begin
          if (base_w >= n_m1) round_pass = 1'b1;
          else begin a_nxt = base_w; state_nxt = EXP; end
        end else begin
          lfsr_nxt = lfsr_step;
          if (lfsr_cand >= TWO && lfsr_cand <= n_m2) begin a_nxt = lfsr_cand; state_nxt = EXP; end
        end
      end
      // Left-to-right exponent scan; leading zeros skipped, first one loads x = a.
      EXP: if (mul_busy) begin
        if (mul_done) x_nxt = mul_acc[W-1:0];
      end else begin
        case (eph)
          E_SCAN: if (e_cnt == '0) begin
            state_nxt = SQR; first_nxt = 1'b1; sq_nxt = s_r - 1'b1;
          end else if (!started) begin
            if (e_d[W-1]) begin x_nxt = a_r; started_nxt = 1'b1; end
            ed_nxt = e_d << 1; ecnt_nxt = e_cnt - 1'b1;
          end else begin
            mul_start = 1'b1; mul_in_a = x_r; mul_in_b = x_r; eph_nxt = E_SQ;
          end
          E_SQ: if (e_d[W-1]) begin
            mul_start = 1'b1; mul_in_a = a_r; mul_in_b = x_r; eph_nxt = E_MUL;
          end else begin
            ed_nxt = e_d << 1; ecnt_nxt = e_cnt - 1'b1; eph_nxt = E_SCAN;
          end
          default: begin ed_nxt = e_d << 1; ecnt_nxt = e_cnt - 1'b1; eph_nxt = E_SCAN; end
        endcase
      end
      SQR: if (mul_busy) begin
        if (mul_done) x_nxt = mul_acc[W-1:0];
      end else if (x_r == n_m1 || (sq_first && x_r == ONE)) round_pass = 1'b1;
      else if (x_r == ONE || sq_left == '0) round_fail = 1'b1;
      else begin
        mul_start = 1'b1; mul_in_a = x_r; mul_in_b = x_r; sq_nxt = sq_left - 1'b1; first_nxt = 1'b0;
      end
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (round_pass) begin
      rr_nxt = rr_r + 6'd1; idx_nxt = idx + 4'd1;
      if (idx + 4'd1 == r_tgt) begin prime_nxt = 1'b1; state_nxt = DONE; end
      else state_nxt = PICK;
    end
    if (round_fail) begin rr_nxt = rr_r + 6'd1; prime_nxt = 1'b0; state_nxt = DONE; end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE; n_r <= '0; d_r <= '0; s_r <= '0; r_tgt <= '0; idx <= '0; rr_r <= '0;
      prime_r <= 1'b0; mode_r <= 1'b0; a_r <= '0; x_r <= '0; e_d <= '0; e_cnt <= '0;
      eph <= E_SCAN; started <= 1'b0; sq_first <= 1'b0; sq_left <= '0; lfsr <= SEED;
`ifdef MR_TRIAL_DIV_EN
      p_idx <= '0; rem <= '0; t_sh <= '0; t_cnt <= '0;
`endif
    end else begin
      state <= state_nxt; n_r <= n_nxt; d_r <= d_nxt; s_r <= s_nxt; r_tgt <= r_nxt; idx <= idx_nxt;
      rr_r <= rr_nxt; prime_r <= prime_nxt; mode_r <= mode_nxt; a_r <= a_nxt; x_r <= x_nxt;
      e_d <= ed_nxt; e_cnt <= ecnt_nxt; eph <= eph_nxt; started <= started_nxt;
      sq_first <= first_nxt; sq_left <= sq_nxt; lfsr <= lfsr_nxt;
`ifdef MR_TRIAL_DIV_EN
      p_idx <= p_idx_nxt; rem <= rem_nxt; t_sh <= t_sh_nxt; t_cnt <= t_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mr_prime_tester.sv
// Scoreboard bench for mr_prime_tester: expected verdicts queued at acceptance, checked at out_valid.
module tb_mr_prime_tester;
  localparam int WW = 32;
`ifdef MR_TRIAL_DIV_EN
  localparam logic [5:0] RR15 = 6'd0;
`else
  localparam logic [5:0] RR15 = 6'd1;
`endif

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, witness_mode, out_valid, out_ready, is_prime, busy;
  logic [WW-1:0] n;
  logic [5:0] security_parameter, rounds_run;
  int total_checks = 0;
  int bad_checks = 0;
  int cyc;

  typedef struct {
    string      tag;
    logic       exp_prime;
    logic [5:0] exp_rr;
    bit         chk_rr;
  } sb_entry_t;
  sb_entry_t sb_q[$];

  logic [WW-1:0] triv_n [5] = '{32'd0, 32'd1, 32'd4, 32'd2, 32'd3};
  logic          triv_p [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  mr_prime_tester #(.WORD_WIDTH(WW), .MAX_ROUNDS(12), .LFSR_SEED(32'hACE1_2468)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .n(n),
    .security_parameter(security_parameter), .witness_mode(witness_mode),
    .out_valid(out_valid), .out_ready(out_ready), .is_prime(is_prime),
    .rounds_run(rounds_run), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [WW-1:0] cand, input logic [5:0] sp,
                               input logic mode, input logic exp_prime, input logic [5:0] exp_rr,
                               input bit chk_rr);
    int waited = 0;
    sb_entry_t e;
    @(negedge clk);
    n = cand; security_parameter = sp; witness_mode = mode; in_valid = 1'b1;
    while (in_ready !== 1'b1 && waited < 1000) begin @(negedge clk); waited++; end
    checkOutput({tag, " accept"}, 64'(in_ready), 64'd1);
    e.tag = tag; e.exp_prime = exp_prime; e.exp_rr = exp_rr; e.chk_rr = chk_rr;
    sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0; n = ~cand; security_parameter = 6'd0;
    checkOutput({tag, " in_ready drop"}, 64'(in_ready), 64'd0);
  endtask

  task automatic collectResult(output int cycles);
    sb_entry_t e;
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 40000) begin @(negedge clk); cycles++; end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checkOutput({e.tag, " out_valid"}, 64'(out_valid), 64'd1);
      checkOutput({e.tag, " is_prime"}, 64'(is_prime), 64'(e.exp_prime));
      if (e.chk_rr) checkOutput({e.tag, " rounds_run"}, 64'(rounds_run), 64'(e.exp_rr));
      @(negedge clk);
      checkOutput({e.tag, " out_valid clear"}, 64'(out_valid), 64'd0);
      checkOutput({e.tag, " in_ready back"}, 64'(in_ready), 64'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; n = '0;
    security_parameter = 6'd0; witness_mode = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset is_prime", 64'(is_prime), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset rounds_run", 64'(rounds_run), 64'd0);
    rst_n = 1'b1;

    // Trivial candidates resolve in PRECHK with a two-cycle latency.
    for (int i = 0; i < 5; i++) begin
      applyStimulus($sformatf("trivial n=%0d", triv_n[i]), triv_n[i], 6'd12, 1'b0, triv_p[i], 6'd0, 1'b1);
      collectResult(cyc);
      checkOutput($sformatf("trivial n=%0d latency", triv_n[i]), 64'(cyc), 64'd1);
    end

    applyStimulus("carmichael 561", 32'd561, 6'd2, 1'b0, 1'b0, 6'd1, 1'b1);
    collectResult(cyc);
    applyStimulus("n=15", 32'd15, 6'd2, 1'b0, 1'b0, RR15, 1'b1);
    collectResult(cyc);
    applyStimulus("n=17 R=12", 32'd17, 6'd12, 1'b0, 1'b1, 6'd12, 1'b1);
    collectResult(cyc);
    applyStimulus("n=17 sp=0", 32'd17, 6'd0, 1'b0, 1'b1, 6'd1, 1'b1);
    collectResult(cyc);
    applyStimulus("n=17 sp=63", 32'd17, 6'd63, 1'b0, 1'b1, 6'd12, 1'b1);
    collectResult(cyc);
    applyStimulus("n=5 R=12", 32'd5, 6'd12, 1'b0, 1'b1, 6'd12, 1'b1);
    collectResult(cyc);
    applyStimulus("spsp235", 32'd25326001, 6'd4, 1'b0, 1'b0, 6'd4, 1'b1);
    collectResult(cyc);
    applyStimulus("spsp2357", 32'd3215031751, 6'd12, 1'b0, 1'b0, 6'd5, 1'b1);
    collectResult(cyc);
    applyStimulus("big prime", 32'd4294967291, 6'd12, 1'b0, 1'b1, 6'd12, 1'b1);
    collectResult(cyc);
    applyStimulus("lfsr n=5", 32'd5, 6'd3, 1'b1, 1'b1, 6'd3, 1'b1);
    collectResult(cyc);
    applyStimulus("lfsr big prime", 32'd4294967291, 6'd2, 1'b1, 1'b1, 6'd2, 1'b1);
    collectResult(cyc);

    // Backpressure: the held result must not move, and new candidates are ignored.
    out_ready = 1'b0;
    applyStimulus("backpressure n=17", 32'd17, 6'd12, 1'b0, 1'b1, 6'd12, 1'b1);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40000) begin @(negedge clk); cyc++; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("bp out_valid", 64'(out_valid), 64'd1);
      checkOutput("bp is_prime", 64'(is_prime), 64'(sb_q[0].exp_prime));
      checkOutput("bp rounds_run", 64'(rounds_run), 64'(sb_q[0].exp_rr));
      checkOutput("bp in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b1; n = 32'd9;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    collectResult(cyc);

    applyStimulus("reset victim", 32'd4294967291, 6'd12, 1'b0, 1'b1, 6'd12, 1'b1);
    repeat (100) @(negedge clk);
    checkOutput("mid busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort in_ready", 64'(in_ready), 64'd1);
    checkOutput("abort out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort is_prime", 64'(is_prime), 64'd0);
    checkOutput("abort rounds_run", 64'(rounds_run), 64'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("lfsr 561", 32'd561, 6'd8, 1'b1, 1'b0, 6'd0, 1'b0);
    collectResult(cyc);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/mr_prime_tester.md
# mr_prime_tester

Parametrised Miller-Rabin primality tester for RSA key generation, the successor to the fixed-function `miller_rabin` block. It tests arbitrary-width odd candidates against up to `MAX_ROUNDS` witnesses. Witnesses come either from a deterministic prime-base list or from an internal LFSR. Candidates enter on a valid/ready input handshake and results leave on a valid/ready output handshake, so the block sits directly between the candidate generator and the key-assembly FSM.

## Interface
- `WORD_WIDTH`, 32: candidate width in bits; must be ≥ 8.
- `MAX_ROUNDS`, 12: upper clamp on the round count; must be in 1..12.
- `LFSR_SEED`, 32'hACE1_2468: reset value of the witness LFSR; a zero seed is forced to 1.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: a candidate is presented.
- `in_ready` output 1: the block is idle and will accept a candidate.
- `n` input `WORD_WIDTH`: candidate; sampled on `in_valid && in_ready`.
- `security_parameter` input 6: requested number of rounds; sampled with `n`.
- `witness_mode` input 1: 0 = deterministic bases {2,3,5,7,11,13,17,19,23,29,31,37}; 1 = LFSR witnesses. Sampled with `n`.
- `out_valid` output 1: a result is available.
- `out_ready` input 1: the consumer accepts the result.
- `is_prime` output 1: 1 = probably prime, 0 = composite.
- `rounds_run` output 6: number of MR rounds executed, including the failing round.
- `busy` output 1: high in every state except IDLE and DONE.

## Operation
- **Round count.** The effective round count R is `security_parameter` clamped to the range 1..`MAX_ROUNDS`; a value of 0 is treated as 1.
- **State machine:** IDLE → PRECHK → [TDIV] → DECOMP → PICK → EXP → SQR → (PICK | DONE) → IDLE.
- **PRECHK (1 cycle):**
  - n < 2 → composite.
  - n == 2 or n == 3 → prime.
  - n even → composite.
  - Each of these goes straight to DONE with `rounds_run` = 0.
- **DECOMP:** shifts d = n−1 right until it is odd, counting s. Takes one cycle per shift, plus one cycle.
- **PICK, deterministic mode:** a = base[i].
  - If a ≥ n−1, the round passes immediately with no exponentiation, and `rounds_run` increments.
- **PICK, LFSR mode:** the LFSR is a 32-bit Galois LFSR with polynomial 0x8020_0003, tiled or truncated to `WORD_WIDTH`.
  - It advances once per PICK cycle.
  - The candidate a = LFSR & (2^bitlen(n)−1).
  - Rejection sampling: if a < 2 or a > n−2, retry next cycle.
- **EXP:** computes x = a^d mod n by left-to-right square-and-multiply over the bits of d.
- **Modular multiplier:** one shared bit-serial interleaved unit.
  - Per operand-B bit, MSB first: r ← 2r mod n, then r ← r+a mod n if the bit is 1.
  - Cost is `WORD_WIDTH` cycles plus 1 cycle per multiply.
  - Intermediates are `WORD_WIDTH`+2 bits wide; every reduction is a single conditional subtract.
- **SQR:**
  - If x == 1 or x == n−1, the round passes.
  - Otherwise square up to s−1 times. Reaching n−1 means pass; exhausting the squarings or reaching 1 means composite.
  - A composite result goes to DONE immediately (early abort).
- **Round progression:** after a passing round, if i+1 == R go to DONE with `is_prime` = 1; otherwise return to PICK.
- **DONE:**
  - `out_valid` = 1; `is_prime` and `rounds_run` are held stable.
  - Leaves to IDLE when `out_ready` = 1.
- **Mid-operation inputs:** `in_valid` is ignored outside IDLE.

## Timing
- **Reset values:**
  - `in_ready` = 1.
  - `out_valid`, `is_prime`, `busy` = 0.
  - `rounds_run` = 0.
  - LFSR = `LFSR_SEED`.
- **Reset mid-operation:** asserting `rst_n` low aborts any test immediately; no result is produced.
- **Handshake cycle timing:**
  - `in_ready` drops the cycle after acceptance.
  - `out_valid` rises the cycle after the final decision.
  - `out_ready` held high during DONE returns the block to IDLE on the next edge; `in_ready` = 1 in that cycle.
- **Latency:**
  - Trivial cases (PRECHK resolved): 2 cycles from acceptance to `out_valid`.
  - Otherwise data-dependent. Each multiply costs `WORD_WIDTH`+1 cycles, and a round costs at most 2·`WORD_WIDTH` multiplies plus s−1 squarings.
- **Back-to-back results:** one result per `out_valid`/`out_ready` handshake; no buffering beyond one result.

## Configuration
- **`MR_TRIAL_DIV_EN`, defined:**
  - A TDIV state is inserted after PRECHK.
  - It computes n mod p for p ∈ {3,5,7,11,13} with a bit-serial remainder, `WORD_WIDTH` cycles per prime.
  - n == p → continue to DECOMP.
  - Remainder 0 → composite, DONE, `rounds_run` = 0.
- **`MR_TRIAL_DIV_EN`, undefined:** TDIV is absent and PRECHK goes directly to DECOMP.

## Test plan
- **Trivial candidates:** n = 0, 1, 4 → `is_prime` = 0, `rounds_run` = 0; n = 2, 3 → `is_prime` = 1, `rounds_run` = 0.
- **Carmichael number:** n = 561, deterministic mode, R = 2 → `is_prime` = 0, `rounds_run` = 1 (base 2 fails).
- **Large prime:** n = 4294967291, deterministic mode, R = 12 → `is_prime` = 1, `rounds_run` = 12; n = 17, R = 12 → `is_prime` = 1, `rounds_run` = 12 (bases ≥ 16 pass trivially).
- **Trial division on/off:** n = 15 → composite; `rounds_run` = 0 with `MR_TRIAL_DIV_EN` defined, 1 without it.
- **Output backpressure:** n = 17, `out_ready` held low for 20 cycles → `out_valid`, `is_prime`, `rounds_run` stable; `in_ready` = 0 until the handshake completes.
- **Reset mid-operation:** `rst_n` low 100 cycles into n = 4294967291 → outputs return to reset values immediately. A following n = 561 in LFSR mode, R = 8 → `is_prime` = 0.
